// File: rtl/seq_mult.sv
// seq_mult: sequential unsigned shift-add multiplier.
// One WIDTH x WIDTH -> 2*WIDTH product per operation, one partial-product
// iteration per clock, with a controller FSM and datapath in one block.
//
// Handshake: start is sampled only while the block is IDLE or DONE. A high
// start on such an edge captures multiplicand/multiplier and launches an
// operation. Operand inputs are don't-care on every other edge. busy is high
// through LOAD and RUN, and start is ignored there. done is a level that is
// held in DONE until the next accepted start or reset. product is registered,
// changes only on DONE entry or reset, and keeps the previous result while a
// new operation runs.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    // One extra counter bit so reaching WIDTH-1 never relies on a wrap.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // state is left as a plainly named register so checkers can bind to it.
    state_t               state;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    // acc = {carry, partial sum, remaining multiplier bits}
    logic [2*WIDTH:0]     acc;
    logic [2*WIDTH:0]     acc_step;
    logic [WIDTH:0]       upper_sum;
    logic [CW-1:0]        count;

    // One shift-add iteration: conditionally add the multiplicand into the
    // upper field (carry lands in the top bit), then shift everything right.
    always_comb begin
        upper_sum = acc[2*WIDTH:WIDTH];
        if (acc[0]) begin
            upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, mcand_r};
        end
        acc_step = {1'b0, upper_sum, acc[WIDTH-1:1]};
    end

    // Controller FSM with registered busy/done/product and the datapath regs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc      <= '0;
            count    <= '0;
            product  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        mcand_r  <= multiplicand;
                        mplier_r <= multiplier;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    acc   <= {1'b0, {WIDTH{1'b0}}, mplier_r};
                    count <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        product <= acc_step[2*WIDTH-1:0];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        mcand_r  <= multiplicand;
                        mplier_r <= multiplier;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        state    <= LOAD;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: randomized and directed bench for seq_mult (WIDTH=8 and WIDTH=4).
// Expected products come from plain a*b arithmetic; expected done edges come
// from the acceptance edge plus WIDTH+1.
module tb_seq_mult;

    localparam int W  = 8;
    localparam int W4 = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic            start = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic [2*W-1:0]  product;
    logic            busy;
    logic            done;

    logic            start4 = 1'b0;
    logic [W4-1:0]   a4 = '0;
    logic [W4-1:0]   b4 = '0;
    logic [2*W4-1:0] product4;
    logic            busy4;
    logic            done4;

    seq_mult #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplicand(a), .multiplier(b),
        .product(product), .busy(busy), .done(done)
    );

    seq_mult #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .multiplicand(a4), .multiplier(b4),
        .product(product4), .busy(busy4), .done(done4)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    // Number of rising edges seen so far; read at negedges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [2*W-1:0]  exp_q[$];
    int              exp_edge_q[$];
    logic [2*W4-1:0] exp4_q[$];
    int              exp4_edge_q[$];

    logic [2*W-1:0]  last_prod = '0;
    logic [2*W-1:0]  e_prod;
    int              e_edge;
    logic            done_prev = 1'b0;
    logic            busy_prev = 1'b0;
    int              busy_run  = 0;

    // Monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e_prod = exp_q.pop_front();
                    e_edge = exp_edge_q.pop_front();
                    check("product", product, e_prod);
                    check("done_edge", cyc, e_edge);
                    check("busy_cycles", busy_run, W + 1);
                    last_prod = e_prod;
                end
            end else begin
                check("product_hold", product, last_prod);
            end
            check("busy_done_excl", {31'd0, busy & done}, 0);
            if (busy && !busy_prev) busy_run = 1;
            else if (busy)          busy_run = busy_run + 1;
            done_prev = done;
            busy_prev = busy;
        end else begin
            done_prev = 1'b0;
            busy_prev = 1'b0;
            busy_run  = 0;
        end
    end

    logic [2*W4-1:0] e4_prod;
    int              e4_edge;
    logic            done4_prev = 1'b0;

    // Monitor for the WIDTH=4 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (done4 && !done4_prev) begin
                if (exp4_q.size() == 0) begin
                    check("w4_unexpected_done", 1, 0);
                end else begin
                    e4_prod = exp4_q.pop_front();
                    e4_edge = exp4_edge_q.pop_front();
                    check("w4_product", product4, e4_prod);
                    check("w4_done_edge", cyc, e4_edge);
                end
            end
            done4_prev = done4;
        end else begin
            done4_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge while the DUT is IDLE or DONE.
    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb);
        logic [2*W-1:0] p;
        p = aa * bb;
        start = 1'b1;
        a = aa;
        b = bb;
        exp_q.push_back(p);
        exp_edge_q.push_back(cyc + 1 + W + 1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
    endtask

    task automatic issue4(input logic [W4-1:0] aa, input logic [W4-1:0] bb);
        logic [2*W4-1:0] p;
        p = aa * bb;
        start4 = 1'b1;
        a4 = aa;
        b4 = bb;
        exp4_q.push_back(p);
        exp4_edge_q.push_back(cyc + 1 + W4 + 1);
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", exp_q.size(), 0);
            exp_q.delete();
            exp_edge_q.delete();
        end
    endtask

    task automatic wait_done4(input int max_cyc);
        int n;
        n = 0;
        while (exp4_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (exp4_q.size() != 0) begin
            check("w4_timeout", exp4_q.size(), 0);
            exp4_q.delete();
            exp4_edge_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2*W-1:0] p1;
        logic [2*W-1:0] p2;
        int acc1;

        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_product", product, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_product4", product4, 0);
        @(negedge clk);
        rst = 1'b0;

        // Idle hold: no start for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", {31'd0, busy}, 0);
            check("idle_done", {31'd0, done}, 0);
            check("idle_product", product, 0);
        end

        // Basic, max operands, zero operand.
        issue(8'd13, 8'd11);
        wait_done(40);
        issue(8'd255, 8'd255);
        wait_done(40);
        issue(8'd0, 8'd200);
        wait_done(40);

        // Back-to-back with start held high.
        p1 = 16'd42;
        p2 = 16'd300;
        start = 1'b1;
        a = 8'd7;
        b = 8'd6;
        acc1 = cyc + 1;
        exp_q.push_back(p1);
        exp_edge_q.push_back(acc1 + W + 1);
        exp_q.push_back(p2);
        exp_edge_q.push_back(acc1 + W + 2 + W + 1);
        @(posedge clk);
        @(negedge clk);
        a = 8'd100;
        b = 8'd3;
        repeat (W + 2) @(negedge clk);
        start = 1'b0;
        wait_done(40);

        // Start during RUN is ignored.
        @(negedge clk);
        issue(8'd5, 8'd9);
        @(negedge clk);
        start = 1'b1;
        a = 8'd1;
        b = 8'd1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(40);
        repeat (15) @(negedge clk);
        check("no_restart_busy", {31'd0, busy}, 0);
        check("no_restart_product", product, 16'd45);

        // Reset asynchronously in the 4th RUN cycle.
        issue(8'd200, 8'd77);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        check("midrst_product", product, 0);
        exp_q.delete();
        exp_edge_q.delete();
        last_prod = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_busy", {31'd0, busy}, 0);
            check("post_rst_done", {31'd0, done}, 0);
        end
        issue(8'd3, 8'd4);
        wait_done(40);

        // Randomized operations with random gaps.
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            wait_done(40);
        end

        // WIDTH=4 instance: basic case then random.
        issue4(4'd15, 4'd15);
        wait_done4(30);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue4(W4'($urandom_range(0, 15)), W4'($urandom_range(0, 15)));
            wait_done4(30);
        end

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size() + exp4_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
